uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port (data / valid / ready handshake) between N_PORTS independent requesters.
- Arbitration is round-robin at packet granularity. A granted requester keeps the transmitter until its last byte is accepted.
- Optional inter-packet idle gap, and a stall watchdog that reclaims the grant from a requester that stops supplying bytes mid-packet.
- Sits between the on-chip byte sources (debug, telemetry, command responses) and the single uart_transmitter instance driving the serial pin.

Parameters:
- N_PORTS, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: byte width; must match the transmitter.
- GAP_CYCLES, 0: idle clock cycles inserted after each packet before the next arbitration; 0 = no gap.
- TIMEOUT_CYCLES, 0: consecutive cycles a granted requester may hold req_valid low mid-packet before its grant is revoked; 0 = watchdog disabled.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- req_data, input, N_PORTS*DATA_WIDTH: requester i byte is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid, input, N_PORTS: requester i has a byte available.
- req_last, input, N_PORTS: the current byte of requester i ends its packet.
- req_ready, output, N_PORTS: byte of requester i accepted this cycle when req_valid[i] is also high.
- tx_data, output, DATA_WIDTH: byte to the transmitter's data_in.
- tx_valid, output, 1: to the transmitter's data_in_valid.
- tx_ready, input, 1: from the transmitter's data_in_ready.
- grant, output, N_PORTS: one-hot current owner; all zeros when no requester owns the transmitter.
- busy, output, 1: high in SEND and GAP.
- timeout_pulse, output, 1: one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (asynchronous): state=IDLE, grant=0, rr_ptr=0, gap and stall counters=0. Outputs tx_valid=0, req_ready=0, busy=0, timeout_pulse=0, tx_data=0.
- Every state update is a registered update on posedge clk.
- tx_data, tx_valid and req_ready are combinational from the registered grant.
- States:
  - IDLE:
    - grant=0, tx_valid=0, all req_ready=0.
    - If any req_valid is high, select the first index with req_valid high, scanning rr_ptr, rr_ptr+1, … modulo N_PORTS.
    - Register the one-hot grant and go to SEND. A request seen at cycle t therefore gives tx_valid at t+1.
  - SEND, owner g:
    - tx_data = req_data[g], tx_valid = req_valid[g], req_ready[g] = tx_ready, all other req_ready = 0.
    - A transfer occurs when req_valid[g] and tx_ready are both high.
    - Transfer with req_last[g]=1: rr_ptr <= (g+1) mod N_PORTS and grant <= 0. Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
    - Non-last transfers keep the grant.
  - GAP:
    - grant=0, tx_valid=0.
    - The counter runs 0..GAP_CYCLES-1. Go to IDLE on the cycle the count reaches GAP_CYCLES-1, giving exactly GAP_CYCLES cycles in GAP.
- Watchdog (TIMEOUT_CYCLES>0):
  - The stall counter clears on any transfer and on entry to SEND.
  - It increments each SEND cycle with req_valid[g]=0. Cycles with req_valid[g]=1 but tx_ready=0 do not count, because a transmitter backpressure stall is not a fault.
  - When the counter reaches TIMEOUT_CYCLES: assert timeout_pulse for that cycle, rr_ptr <= (g+1) mod N_PORTS, grant <= 0, next state GAP or IDLE as for a normal end of packet.
  - Any remaining bytes of the revoked packet are later arbitrated as a new packet.
- Simultaneous events:
  - Requests arriving during SEND or GAP wait. Their req_ready stays 0.
  - A requester that drops req_valid while not granted is not remembered.
  - req_last on a single-byte packet ends the packet on its only transfer.
  - On a last-byte transfer, the following IDLE cycle re-arbitrates using the updated rr_ptr. The same requester wins only if no other requester is valid.
- rr_ptr width is clog2(N_PORTS). Wrap from N_PORTS-1 to 0 must be correct for non-power-of-two N_PORTS.
- Mid-packet reset drops the grant and tx_valid immediately. A character the transmitter has already accepted completes under the transmitter's own control. The upstream source is responsible for discarding its packet.
- grant is always zero or one-hot. The bench asserts this every cycle.

Test Plan:
- Single source, N_PORTS=4, GAP=0: port 2 sends 0x41, 0x42, 0x43 with last on 0x43; tx_ready toggles 1,0,1,0. Required: tx_data sequence 0x41, 0x42, 0x43; grant=4'b0100 throughout; state back to IDLE the cycle after the third transfer.
- Contention: ports 0 and 3 each raise a 2-byte packet in the same cycle, rr_ptr=0. Required: port 0 packet fully first, then port 3; rr_ptr=1 after the first packet and 0 after the second (wrap).
- Fairness: all 4 ports continuously valid with 1-byte packets. Required: grant order 0,1,2,3,0,1,… with no port served twice before each other port is served once.
- Gap: GAP_CYCLES=3, two back-to-back packets from port 1. Required: exactly 3 cycles with busy=1, tx_valid=0 and grant=0 between the last transfer and the next grant.
- Watchdog: TIMEOUT_CYCLES=5; port 0 sends one byte (not last), then holds req_valid low. Required: timeout_pulse high on the 5th stalled cycle, grant=0 next cycle, port 1 (waiting) granted on the following arbitration. Separately, tx_ready held low for 20 cycles with req_valid high gives no timeout.
- Reset mid-packet: assert reset between bytes 2 and 3 of a port-1 packet. Required: grant, tx_valid and req_ready go to 0 without waiting for a clock edge; after release rr_ptr=0, state IDLE, and port 0 wins if ports 0 and 1 are both valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter byte port between N_PORTS requesters.
// Grants are held for a whole packet; optional inter-packet gap and mid-packet stall watchdog.
module uart_tx_arbiter #(
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [N_PORTS-1:0]            req_valid,
    input  logic [N_PORTS-1:0]            req_last,
    output logic [N_PORTS-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [N_PORTS-1:0]            grant,
    output logic                          busy,
    output logic                          timeout_pulse
);
    localparam int unsigned PTR_W = $clog2(N_PORTS);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [PTR_W-1:0]   PTR_MAX  = PTR_W'(N_PORTS - 1);
    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   pick;
    logic [PTR_W-1:0]   scan_idx;
    logic               end_pkt;

    // Datapath mux and owner index both decode straight from the registered one-hot grant.
    always_comb begin
        tx_data = '0;
        owner   = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) begin
                tx_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                owner   = PTR_W'(i);
            end
        end
    end

    assign grant     = grant_q;
    assign tx_valid  = |(grant_q & req_valid);
    assign req_ready = tx_ready ? grant_q : '0;
    assign busy      = (state_q != IDLE);
    assign next_ptr  = (owner == PTR_MAX) ? '0 : owner + 1'b1;

    // Scan from the highest offset down so the nearest valid index after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr_q;
        scan_idx = '0;
        for (int unsigned k = N_PORTS; k > 0; k--) begin
            scan_idx = PTR_W'((32'(rr_ptr_q) + k - 1) % N_PORTS);
            if (req_valid[scan_idx]) begin
                pick = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        gap_cnt_d     = gap_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        end_pkt       = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d     = ONE_HOT0 << pick;
                    stall_cnt_d = '0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (tx_valid && tx_ready) begin
                    stall_cnt_d = '0;
                    end_pkt     = |(grant_q & req_last);
                end else if (TIMEOUT_CYCLES > 0 && !tx_valid) begin
                    // Only owner starvation counts; transmitter backpressure is not a fault.
                    if (stall_cnt_q == TO_LAST) begin
                        timeout_pulse = 1'b1;
                        end_pkt       = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
                if (end_pkt) begin
                    grant_d   = '0;
                    rr_ptr_d  = next_ptr;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            gap_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            gap_cnt_q   <= gap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-port instance (no gap, watchdog 5) and a
// 3-port instance (gap 3, no watchdog), driven from a vector table plus hand sequences.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: N_PORTS=4, GAP_CYCLES=0, TIMEOUT_CYCLES=5
    logic [31:0] a_data = '0;
    logic [3:0]  a_valid = '0, a_last = '0, a_ready, a_grant;
    logic [7:0]  a_txd;
    logic        a_txv, a_rdy = 1'b0, a_busy, a_to;

    uart_tx_arbiter #(.N_PORTS(4), .DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(5)) dut_a (
        .clk(clk), .reset(reset), .req_data(a_data), .req_valid(a_valid), .req_last(a_last),
        .req_ready(a_ready), .tx_data(a_txd), .tx_valid(a_txv), .tx_ready(a_rdy),
        .grant(a_grant), .busy(a_busy), .timeout_pulse(a_to)
    );

    // Instance B: N_PORTS=3 (non-power-of-two wrap), GAP_CYCLES=3, watchdog off
    logic [23:0] b_data = '0;
    logic [2:0]  b_valid = '0, b_last = '0, b_ready, b_grant;
    logic [7:0]  b_txd;
    logic        b_txv, b_rdy = 1'b0, b_busy, b_to;

    uart_tx_arbiter #(.N_PORTS(3), .DATA_WIDTH(8), .GAP_CYCLES(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .req_data(b_data), .req_valid(b_valid), .req_last(b_last),
        .req_ready(b_ready), .tx_data(b_txd), .tx_valid(b_txv), .tx_ready(b_rdy),
        .grant(b_grant), .busy(b_busy), .timeout_pulse(b_to)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  g;
        logic        tv;
        logic [7:0]  td;
        logic [3:0]  rd;
        logic        bz;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic r, input logic [3:0] g, input logic tv,
                                input logic [7:0] td, input logic [3:0] rd, input logic bz);
        vec_t x;
        x.valid = v; x.last = l; x.data = d; x.rdy = r;
        x.g = g; x.tv = tv; x.td = td; x.rd = rd; x.bz = bz;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick_a(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                          input logic r);
        @(negedge clk);
        a_valid = v; a_last = l; a_data = d; a_rdy = r;
        #1;
    endtask

    task automatic tick_b(input logic [2:0] v, input logic [2:0] l, input logic [23:0] d,
                          input logic r);
        @(negedge clk);
        b_valid = v; b_last = l; b_data = d; b_rdy = r;
        #1;
    endtask

    // Grant must be zero or one-hot on every cycle of both instances.
    always @(negedge clk) begin
        if (!reset) begin
            n_cmp++;
            if (!$onehot0(a_grant) || !$onehot0(b_grant)) begin
                n_err++;
                $display("FAIL onehot: grant_a=%b grant_b=%b, expected zero or one-hot", a_grant, b_grant);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Contention ports 0 and 3 (rr_ptr=0), then 4-way fairness, then single source port 2.
        tbl[0]  = mk(4'b1001, 4'b0000, 32'hD00000A0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[1]  = mk(4'b1001, 4'b0000, 32'hD00000A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 4'b0001, 1'b1);
        tbl[2]  = mk(4'b1001, 4'b0001, 32'hD00000A1, 1'b1, 4'b0001, 1'b1, 8'hA1, 4'b0001, 1'b1);
        tbl[3]  = mk(4'b1000, 4'b0000, 32'hD0000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[4]  = mk(4'b1000, 4'b0000, 32'hD0000000, 1'b1, 4'b1000, 1'b1, 8'hD0, 4'b1000, 1'b1);
        tbl[5]  = mk(4'b1000, 4'b1000, 32'hD1000000, 1'b1, 4'b1000, 1'b1, 8'hD1, 4'b1000, 1'b1);
        tbl[6]  = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[7]  = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1);
        tbl[8]  = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[9]  = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1);
        tbl[10] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[11] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h12, 4'b0100, 1'b1);
        tbl[12] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[13] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h13, 4'b1000, 1'b1);
        tbl[14] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[15] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h10, 4'b0001, 1'b1);
        tbl[16] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[17] = mk(4'b1111, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1);
        tbl[18] = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[19] = mk(4'b0100, 4'b0000, 32'h00410000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);
        tbl[20] = mk(4'b0100, 4'b0000, 32'h00410000, 1'b1, 4'b0100, 1'b1, 8'h41, 4'b0100, 1'b1);
        tbl[21] = mk(4'b0100, 4'b0000, 32'h00420000, 1'b0, 4'b0100, 1'b1, 8'h42, 4'b0000, 1'b1);
        tbl[22] = mk(4'b0100, 4'b0000, 32'h00420000, 1'b1, 4'b0100, 1'b1, 8'h42, 4'b0100, 1'b1);
        tbl[23] = mk(4'b0100, 4'b0100, 32'h00430000, 1'b0, 4'b0100, 1'b1, 8'h43, 4'b0000, 1'b1);
        tbl[24] = mk(4'b0100, 4'b0100, 32'h00430000, 1'b1, 4'b0100, 1'b1, 8'h43, 4'b0100, 1'b1);
        tbl[25] = mk(4'b0000, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0);

        #3;
        chk("reset a outputs", {a_grant, a_txv, a_txd, a_ready, a_busy, a_to}, '0);
        chk("reset b outputs", {b_grant, b_txv, b_txd, b_ready, b_busy, b_to}, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 26; i++) begin
            tick_a(tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].rdy);
            chk($sformatf("tbl%0d grant", i), 32'(a_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d tx", i), 32'({a_txv, a_txd}), 32'({tbl[i].tv, tbl[i].td}));
            chk($sformatf("tbl%0d req_ready", i), 32'(a_ready), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d busy/timeout", i), 32'({a_busy, a_to}), 32'({tbl[i].bz, 1'b0}));
        end

        // Transmitter backpressure for 20 cycles must not trip the watchdog.
        tick_a(4'b1000, 4'b1000, 32'h55000000, 1'b0);
        chk("bp idle", 32'({a_busy, a_grant}), 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick_a(4'b1000, 4'b1000, 32'h55000000, 1'b0);
            chk($sformatf("bp%0d hold", i), 32'({a_grant, a_txv, a_to}), 32'({4'b1000, 1'b1, 1'b0}));
        end
        tick_a(4'b1000, 4'b1000, 32'h55000000, 1'b1);
        chk("bp accept", 32'({a_ready, a_txd}), 32'({4'b1000, 8'h55}));

        // Watchdog: port 0 sends one non-last byte then starves; port 1 waits.
        tick_a(4'b0011, 4'b0010, 32'h00008877, 1'b1);
        chk("wd idle", 32'(a_grant), 32'h0);
        tick_a(4'b0011, 4'b0010, 32'h00008877, 1'b1);
        chk("wd first byte", 32'({a_grant, a_txv, a_txd}), 32'({4'b0001, 1'b1, 8'h77}));
        for (int s = 1; s <= 5; s++) begin
            tick_a(4'b0010, 4'b0010, 32'h00008877, 1'b1);
            chk($sformatf("wd stall%0d", s), 32'({a_grant, a_txv, a_to}),
                32'({4'b0001, 1'b0, (s == 5) ? 1'b1 : 1'b0}));
        end
        tick_a(4'b0010, 4'b0010, 32'h00008877, 1'b1);
        chk("wd revoked", 32'({a_grant, a_busy, a_to}), 32'h0);
        tick_a(4'b0010, 4'b0010, 32'h00008877, 1'b1);
        chk("wd port1 granted", 32'({a_grant, a_txv, a_txd}), 32'({4'b0010, 1'b1, 8'h88}));
        tick_a(4'b0000, 4'b0000, 32'h0, 1'b1);

        // Reset between bytes 2 and 3 of a port-1 packet.
        tick_a(4'b0010, 4'b0000, 32'h00000100, 1'b1);
        tick_a(4'b0010, 4'b0000, 32'h00000100, 1'b1);
        chk("rst byte1", 32'({a_grant, a_txd}), 32'({4'b0010, 8'h01}));
        tick_a(4'b0010, 4'b0000, 32'h00000200, 1'b1);
        chk("rst byte2", 32'({a_grant, a_txd}), 32'({4'b0010, 8'h02}));
        tick_a(4'b0010, 4'b0010, 32'h00000300, 1'b1);
        chk("rst byte3 presented", 32'({a_grant, a_txv}), 32'({4'b0010, 1'b1}));
        #1 reset = 1'b1;
        #1;
        chk("rst async drop", 32'({a_grant, a_txv, a_ready, a_busy}), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        a_valid = 4'b0011; a_last = 4'b0011; a_data = 32'h0000BBAA; a_rdy = 1'b1;
        #1;
        chk("rst released idle", 32'({a_grant, a_busy}), 32'h0);
        tick_a(4'b0011, 4'b0011, 32'h0000BBAA, 1'b1);
        chk("rst port0 wins", 32'({a_grant, a_txd}), 32'({4'b0001, 8'hAA}));
        tick_a(4'b0000, 4'b0000, 32'h0, 1'b0);

        // Instance B: two back-to-back packets from port 1 with a 3-cycle gap.
        tick_b(3'b010, 3'b010, 24'h00B100, 1'b1);
        chk("gap idle", 32'({b_grant, b_busy}), 32'h0);
        tick_b(3'b010, 3'b010, 24'h00B100, 1'b1);
        chk("gap pkt1", 32'({b_grant, b_txd, b_ready}), 32'({3'b010, 8'hB1, 3'b010}));
        for (int i = 0; i < 3; i++) begin
            tick_b(3'b010, 3'b010, 24'h00B100, 1'b1);
            chk($sformatf("gap cycle%0d", i), 32'({b_busy, b_txv, b_grant, b_ready}), 32'({1'b1, 7'b0}));
        end
        tick_b(3'b010, 3'b010, 24'h00B100, 1'b1);
        chk("gap end idle", 32'({b_busy, b_grant}), 32'h0);
        tick_b(3'b010, 3'b010, 24'h00B100, 1'b1);
        chk("gap pkt2", 32'({b_grant, b_txd}), 32'({3'b010, 8'hB1}));

        // Instance B: rr_ptr=2 after port 1, then port 2 must wrap the pointer to 0.
        for (int i = 0; i < 3; i++) begin
            tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
            chk($sformatf("wrap gapA%0d", i), 32'({b_busy, b_grant}), 32'({1'b1, 3'b000}));
        end
        tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
        chk("wrap idleA", 32'({b_busy, b_grant}), 32'h0);
        tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
        chk("wrap port2", 32'({b_grant, b_txd}), 32'({3'b100, 8'hC2}));
        for (int i = 0; i < 3; i++) begin
            tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
            chk($sformatf("wrap gapB%0d", i), 32'({b_busy, b_grant, b_to}), 32'({1'b1, 4'b0000}));
        end
        tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
        chk("wrap idleB", 32'({b_busy, b_grant}), 32'h0);
        tick_b(3'b101, 3'b101, 24'hC200C0, 1'b1);
        chk("wrap port0", 32'({b_grant, b_txd}), 32'({3'b001, 8'hC0}));
        tick_b(3'b000, 3'b000, 24'h0, 1'b0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
